// File: rtl/bus_arb_rr2.sv
// bus_arb_rr2: two-master round-robin arbiter for the internal register bus.
// Define ARB_DROP_CNT_EN to add saturating per-master dropped-request counters.
module bus_arb_rr2 #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_busy,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_busy,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef ARB_DROP_CNT_EN
  output logic [15:0]       m0_drop_cnt,
  output logic [15:0]       m1_drop_cnt,
`endif
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_rd,
  output logic              bus_wr,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_vld;
  logic [1:0]        r_we;
  logic [ADDR_W-1:0] r_addr0;
  logic [ADDR_W-1:0] r_addr1;
  logic [DATA_W-1:0] r_wdata0;
  logic [DATA_W-1:0] r_wdata1;
  logic              r_win;
  logic              r_last;
  logic              r_bus_we;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic w_ack0;
  logic w_ack1;
  logic w_take0;
  logic w_take1;
  logic w_sel;
  logic w_load;
  logic w_sample;

  assign w_ack0  = (r_state == S_DONE) & ~r_win;
  assign w_ack1  = (r_state == S_DONE) & r_win;
  // a slot being acknowledged this cycle may be refilled at once
  assign w_take0 = m0_req & (~r_vld[0] | w_ack0);
  assign w_take1 = m1_req & (~r_vld[1] | w_ack1);
  assign w_sel   = (r_vld == 2'b10) |
                   ((r_vld == 2'b11) & ~r_last);

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_sample = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_vld) begin
          w_next = S_ISSUE;
          w_load = 1'b1;
        end
      end
      S_ISSUE: begin
        w_next = r_bus_we ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_sample = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_vld    <= '0;
      r_we     <= '0;
      r_addr0  <= '0;
      r_addr1  <= '0;
      r_wdata0 <= '0;
      r_wdata1 <= '0;
    end else begin
      if (w_take0) begin
        r_vld[0] <= 1'b1;
        r_we[0]  <= m0_we;
        r_addr0  <= m0_addr;
        r_wdata0 <= m0_wdata;
      end else if (w_ack0) begin
        r_vld[0] <= 1'b0;
      end
      if (w_take1) begin
        r_vld[1] <= 1'b1;
        r_we[1]  <= m1_we;
        r_addr1  <= m1_addr;
        r_wdata1 <= m1_wdata;
      end else if (w_ack1) begin
        r_vld[1] <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_win       <= 1'b0;
      r_last      <= 1'b1;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_cnt       <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      if (w_load) begin
        r_win       <= w_sel;
        r_bus_we    <= w_sel ? r_we[1] : r_we[0];
        r_bus_addr  <= w_sel ? r_addr1 : r_addr0;
        r_bus_wdata <= w_sel ? r_wdata1 : r_wdata0;
      end
      if (r_state == S_ISSUE && !r_bus_we) begin
        r_cnt <= LAT_M1;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_sample && r_win) begin
        r_rdata1 <= bus_rdata;
      end
      if (w_sample && !r_win) begin
        r_rdata0 <= bus_rdata;
      end
      if (r_state == S_DONE) begin
        r_last <= r_win;
      end
    end
  end

`ifdef ARB_DROP_CNT_EN
  logic        w_drop0;
  logic        w_drop1;
  logic [15:0] r_drop0;
  logic [15:0] r_drop1;

  assign w_drop0 = m0_req & ~w_take0;
  assign w_drop1 = m1_req & ~w_take1;

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_drop0 <= '0;
      r_drop1 <= '0;
    end else begin
      if (w_drop0 && r_drop0 != 16'hFFFF) begin
        r_drop0 <= r_drop0 + 16'd1;
      end
      if (w_drop1 && r_drop1 != 16'hFFFF) begin
        r_drop1 <= r_drop1 + 16'd1;
      end
    end
  end

  assign m0_drop_cnt = r_drop0;
  assign m1_drop_cnt = r_drop1;
`endif

  assign m0_busy   = r_vld[0] & ~w_ack0;
  assign m1_busy   = r_vld[1] & ~w_ack1;
  assign m0_ack    = w_ack0;
  assign m1_ack    = w_ack1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_rd    = (r_state == S_ISSUE) & ~r_bus_we;
  assign bus_wr    = (r_state == S_ISSUE) & r_bus_we;

endmodule

// File: tb/tb_bus_arb_rr2.sv
// tb_bus_arb_rr2: vector table plus scoreboard bench for bus_arb_rr2.
// Instances run with RD_LAT 2 (main), 1 and 15; ARB_DROP_CNT_EN optional.
module tb_bus_arb_rr2;

  typedef struct {
    bit          m;
    bit          we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0;
  logic        m0_we = 1'b0;
  logic [29:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m1_req = 1'b0;
  logic        m1_we = 1'b0;
  logic [29:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;

  logic [2:0]  v_m0_busy, v_m0_ack, v_m1_busy, v_m1_ack, v_rd, v_wr;
  logic [31:0] v_m0_rdata [3];
  logic [31:0] v_m1_rdata [3];
  logic [31:0] v_wdata [3];
  logic [31:0] v_rdata [3];
  logic [29:0] v_addr [3];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_ack = 0;
  int   n_strb = 0;
  int   ack_c = 0;
  int   strb_c = 0;
  int   gap = 0;
  txn_t busq[$];
  txn_t ackq[$];
  txn_t vec[7];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_val(input logic [29:0] a);
    return (a == 30'h3) ? 32'h1234_5678 : ~{2'b00, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp_v, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    logic [15:0] sr = '0;
    int rd_c = 0;
    int ak_c = 0;
`ifdef ARB_DROP_CNT_EN
    logic [15:0] dc0, dc1;
`endif
    bus_arb_rr2 #(.RD_LAT(L)) u_dut (
      .aclk(aclk),
      .reset(reset),
      .m0_req(m0_req),
      .m0_we(m0_we),
      .m0_addr(m0_addr),
      .m0_wdata(m0_wdata),
      .m0_busy(v_m0_busy[g]),
      .m0_ack(v_m0_ack[g]),
      .m0_rdata(v_m0_rdata[g]),
      .m1_req(m1_req),
      .m1_we(m1_we),
      .m1_addr(m1_addr),
      .m1_wdata(m1_wdata),
      .m1_busy(v_m1_busy[g]),
      .m1_ack(v_m1_ack[g]),
      .m1_rdata(v_m1_rdata[g]),
`ifdef ARB_DROP_CNT_EN
      .m0_drop_cnt(dc0),
      .m1_drop_cnt(dc1),
`endif
      .bus_addr(v_addr[g]),
      .bus_wdata(v_wdata[g]),
      .bus_rd(v_rd[g]),
      .bus_wr(v_wr[g]),
      .bus_rdata(v_rdata[g])
    );
    // register file model: data valid only L cycles after bus_rd
    always @(posedge aclk) sr <= {sr[14:0], v_rd[g]};
    assign v_rdata[g] = sr[L-1] ? rd_val(v_addr[g]) : 32'hBAD0_BAD0;
    always @(negedge aclk) begin
      if (!reset) begin
        if (v_rd[g] | v_wr[g])
          chk("strobe_excl", 64'(v_rd[g] & v_wr[g]), 64'd0);
        if (v_rd[g]) rd_c = cyc;
        if (v_m1_ack[g]) ak_c = cyc;
      end
    end
  end

  always @(negedge aclk) begin : mon
    txn_t e;
    if (!reset) begin
      if (v_rd[0] | v_wr[0]) begin
        n_strb++;
        gap = cyc - ack_c;
        strb_c = cyc;
        if (busq.size() == 0) fail("bus_unexpected");
        else begin
          e = busq.pop_front();
          chk("bus_we", 64'(v_wr[0]), 64'(e.we));
          chk("bus_addr", 64'(v_addr[0]), 64'(e.addr));
          if (e.we) chk("bus_wdata", 64'(v_wdata[0]), 64'(e.wdata));
        end
      end
      if (v_m0_ack[0] | v_m1_ack[0]) begin
        n_ack++;
        ack_c = cyc;
        if (ackq.size() == 0) fail("ack_unexpected");
        else begin
          e = ackq.pop_front();
          chk("ack_master", {v_m1_ack[0], v_m0_ack[0]},
              e.m ? 2'b10 : 2'b01);
          if (!e.we)
            chk("ack_rdata", e.m ? v_m1_rdata[0] : v_m0_rdata[0],
                64'(e.rdata));
        end
      end
    end
  end

  task automatic set_req(input bit m, input bit we, input logic [29:0] a,
                         input logic [31:0] d, input logic [31:0] rd,
                         input bit push);
    txn_t t;
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
    end
    if (push) begin
      t = '{m: m, we: we, addr: a, wdata: d, rdata: rd};
      busq.push_back(t);
      ackq.push_back(t);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic wait_acks(input int target, input int budget,
                           input string nm);
    int k = 0;
    while (n_ack < target && k < budget) begin
      tick();
      k++;
    end
    if (n_ack < target) fail({nm, "_timeout"});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    busq.delete();
    ackq.delete();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, base, s0, nb, k;
    vec[0] = '{m: 0, we: 1, addr: 30'h11, wdata: 32'h0BAD_F00D, rdata: 0};
    vec[1] = '{m: 1, we: 0, addr: 30'h3, wdata: 0, rdata: 32'h1234_5678};
    vec[2] = '{m: 1, we: 1, addr: 30'h3FFF_FFFF, wdata: 32'hA5A5_A5A5,
               rdata: 0};
    vec[3] = '{m: 0, we: 0, addr: 30'h20, wdata: 0, rdata: 32'hFFFF_FFDF};
    vec[4] = '{m: 0, we: 1, addr: 30'h0, wdata: 32'hFFFF_FFFF, rdata: 0};
    vec[5] = '{m: 1, we: 0, addr: 30'h3FFF_FFFF, wdata: 0,
               rdata: 32'hC000_0000};
    vec[6] = '{m: 0, we: 0, addr: 30'h0, wdata: 0, rdata: 32'hFFFF_FFFF};

    repeat (3) @(negedge aclk);
    chk("rst_flags", {v_m0_busy[0], v_m0_ack[0], v_m1_busy[0],
                      v_m1_ack[0], v_rd[0], v_wr[0]}, 0);
    chk("rst_rdata", v_m0_rdata[0] | v_m1_rdata[0], 0);
    chk("rst_bus", {v_addr[0], v_wdata[0]}, 0);
    @(posedge aclk);
    #1;
    reset = 1'b0;

    // single write, cycle-exact
    set_req(0, 1, 30'h10, 32'hDEAD_BEEF, 0, 1);
    tick();
    @(negedge aclk);
    chk("wr_busy_c1", v_m0_busy[0], 1);
    chk("wr_nostrobe_c1", v_wr[0], 0);
    @(negedge aclk);
    chk("wr_busy_c2", v_m0_busy[0], 1);
    chk("wr_strobe_c2", v_wr[0], 1);
    @(negedge aclk);
    chk("wr_busy_c3", v_m0_busy[0], 0);
    chk("wr_ack_c3", v_m0_ack[0], 1);
    tick();

    for (int i = 0; i < 7; i++) begin
      base = n_ack;
      c0 = cyc;
      set_req(vec[i].m, vec[i].we, vec[i].addr, vec[i].wdata,
              vec[i].rdata, 1);
      tick();
      wait_acks(base + 1, 30, "vec");
      chk("vec_strobe_lat", strb_c - c0, 2);
      chk("vec_ack_lat", ack_c - c0, vec[i].we ? 3 : 5);
    end

    // simultaneous requests: master 0 wins every tie (last_grant=1)
    do_reset();
    for (int r = 0; r < 4; r++) begin
      base = n_ack;
      set_req(0, r[0] == 1'b0, 30'h100 + r, 32'hA000_0000 + r,
              32'hFFFF_FEFF - r, 1);
      set_req(1, r[0] == 1'b1, 30'h200 + r, 32'hB000_0000 + r,
              32'hFFFF_FDFF - r, 1);
      tick();
      wait_acks(base + 2, 40, "tie");
      chk("tie_gap", gap, 2);
    end

    // overflow, no preemption, refill in the ack cycle
    do_reset();
    base = n_ack;
    s0 = n_strb;
    set_req(0, 1, 30'h55, 32'h5555_5555, 0, 1);
    tick();
    set_req(0, 1, 30'h66, 32'h6666_6666, 0, 0);
    tick();
    set_req(1, 0, 30'h3, 0, 32'h1234_5678, 1);
    tick();
    set_req(0, 1, 30'h77, 32'h7777_7777, 0, 1);
    @(negedge aclk);
    chk("ovf_ack_c3", v_m0_ack[0], 1);
    tick();
    @(negedge aclk);
    chk("ovf_refill_busy", v_m0_busy[0], 1);
    wait_acks(base + 3, 60, "ovf");
    chk("ovf_strobes", n_strb - s0, 3);
`ifdef ARB_DROP_CNT_EN
    chk("ovf_drop0", g_dut[0].dc0, 1);
    chk("ovf_drop1", g_dut[0].dc1, 0);
`endif
    repeat (30) tick();

    // reset during WAIT
    base = n_ack;
    s0 = n_strb;
    nb = g_dut[1].ak_c + g_dut[2].ak_c;
    set_req(1, 0, 30'h3, 0, 32'h1234_5678, 1);
    tick();
    tick();
    tick();
    reset = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    chk("midrst_flags", {v_m0_busy[0], v_m0_ack[0], v_m1_busy[0],
                         v_m1_ack[0], v_rd[0], v_wr[0]}, 0);
    chk("midrst_rdata", v_m0_rdata[0] | v_m1_rdata[0], 0);
    chk("midrst_bus", {v_addr[0], v_wdata[0]}, 0);
    busq.delete();
    ackq.delete();
    tick();
    reset = 1'b0;
    repeat (25) tick();
    chk("midrst_no_ack", n_ack - base, 0);
    chk("midrst_no_strobe", n_strb - s0, 1);
    chk("midrst_sweep_ack", g_dut[1].ak_c + g_dut[2].ak_c - nb, 0);

    // RD_LAT sweep: 1 and 15
    do_reset();
    base = n_ack;
    c0 = cyc;
    set_req(1, 0, 30'h44, 0, 32'hFFFF_FFBB, 1);
    tick();
    wait_acks(base + 1, 30, "sweep_main");
    k = 0;
    while (g_dut[2].ak_c <= g_dut[2].rd_c && k < 60) begin
      tick();
      k++;
    end
    if (g_dut[2].ak_c <= g_dut[2].rd_c) fail("lat15_timeout");
    chk("lat1_strobe", g_dut[1].rd_c - c0, 2);
    chk("lat1_ack", g_dut[1].ak_c - g_dut[1].rd_c, 2);
    chk("lat1_rdata", v_m1_rdata[1], 32'hFFFF_FFBB);
    chk("lat15_strobe", g_dut[2].rd_c - c0, 2);
    chk("lat15_ack", g_dut[2].ak_c - g_dut[2].rd_c, 16);
    chk("lat15_rdata", v_m1_rdata[2], 32'hFFFF_FFBB);
    chk("q_empty", busq.size() + ackq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
